// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map, region and FSM encodings shared by the memory
// responder and its RAM.
//   LEDR_ADDR / SW_ADDR / RAM_BASE : fixed byte addresses of the mapped resources
//   region_e                       : decode result of a request address
//   state_e                        : responder handshake state
//   decode_region()                : word-granular address decode (addr[1:0] ignored)
package mem_map_pkg;

    localparam logic [31:0] LEDR_ADDR = 32'h0010_000C;
    localparam logic [31:0] SW_ADDR   = 32'h0010_0010;
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;

    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_LEDR = 2'd1,
        RGN_SW   = 2'd2,
        RGN_NONE = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Compare word addresses only, so byte offsets within a word never change
    // the region. ram_words is the RAM depth in 32-bit words.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_words);
        logic [31:0] word_addr;
        logic [31:0] word_base;
        region_e     rgn;
        word_addr = {2'b00, addr[31:2]};
        word_base = {2'b00, RAM_BASE[31:2]};
        if (word_addr - word_base < ram_words) begin
            rgn = RGN_RAM;
        end else if (addr[31:2] == LEDR_ADDR[31:2]) begin
            rgn = RGN_LEDR;
        end else if (addr[31:2] == SW_ADDR[31:2]) begin
            rgn = RGN_SW;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: single-port WORDS x 32 synchronous RAM, block-RAM
// inferable, one-cycle registered read (read-before-write). Contents are
// never reset.
//   clk   : clock
//   en    : access enable (read or write this cycle)
//   we    : write enable (qualified by en)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, valid the cycle after an enabled access
module mem_responder_ram #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: target end of the cpu memory bus. Accepts one read/write
// strobe at a time, decodes it to RAM / LEDR / SW / unmapped, performs it
// after WAIT_CYCLES wait states and pulses mem_ack for one cycle.
//   clk, reset_n         : clock, asynchronous active-low reset
//   mem_read, mem_write  : one-cycle request strobes (both high = write)
//   mem_addr             : byte address (bits [1:0] ignored)
//   mem_write_data       : write data
//   mem_ack              : one-cycle completion pulse
//   mem_read_data        : read data, valid with mem_ack (0 for writes)
//   sw                   : asynchronous board switches (2-flop synchronized)
//   ledr                 : LEDR register
//   bus_err              : pulses with mem_ack for unmapped accesses
//   protocol_err         : sticky flag for illegal strobes
module mem_responder #(
    parameter int unsigned RAM_WORDS     = 1024,
    parameter int unsigned WAIT_CYCLES   = 1,
    parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic        mem_ack,
    output logic [31:0] mem_read_data,
    input  logic [17:0] sw,
    output logic [17:0] ledr,
    output logic        bus_err,
    output logic        protocol_err
);
    import mem_map_pkg::*;

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  ram_idx_q;
    logic [31:0]    wdata_q;
    logic           write_q;
    region_e        region_q;
    logic [17:0]    ledr_q;
    logic [17:0]    sw_meta_q, sw_sync_q;
    logic [31:0]    rdata_hold_q;
    logic           proto_err_q;

    logic           strobe;
    logic           issue;
    region_e        req_region;
    logic           op_write;
    region_e        op_region;
    logic [AW-1:0]  op_idx;
    logic [31:0]    op_wdata;
    logic           ram_en, ram_we;
    logic [31:0]    ram_rdata;
    logic [31:0]    ack_data;

    assign strobe     = mem_read | mem_write;
    assign req_region = decode_region(mem_addr, 32'(RAM_WORDS));

    // With no wait states the access is issued in the same cycle the strobe
    // is accepted, so operands come straight from the bus; otherwise from
    // the captured copies.
    always_comb begin
        if (state_q == IDLE) begin
            op_write  = mem_write;
            op_region = req_region;
            op_idx    = mem_addr[AW+1:2];
            op_wdata  = mem_write_data;
        end else begin
            op_write  = write_q;
            op_region = region_q;
            op_idx    = ram_idx_q;
            op_wdata  = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        mem_ack = 1'b0;
        bus_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACK;
                        issue   = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Counter value 1 marks the last wait cycle: issue the access
                // here so the registered RAM output is ready in ACK.
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                    issue   = 1'b1;
                end
            end
            ACK: begin
                mem_ack = 1'b1;
                bus_err = (region_q == RGN_NONE);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_en = issue && (op_region == RGN_RAM);
    assign ram_we = ram_en && op_write;

    mem_responder_ram #(
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (op_idx),
        .wdata (op_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        ack_data = 32'h0;
        if (!write_q) begin
            case (region_q)
                RGN_RAM:  ack_data = ram_rdata;
                RGN_LEDR: ack_data = {14'b0, ledr_q};
                RGN_SW:   ack_data = {14'b0, sw_sync_q};
                default:  ack_data = UNMAPPED_DATA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            ram_idx_q    <= '0;
            wdata_q      <= 32'h0;
            write_q      <= 1'b0;
            region_q     <= RGN_NONE;
            ledr_q       <= 18'h0;
            sw_meta_q    <= 18'h0;
            sw_sync_q    <= 18'h0;
            rdata_hold_q <= 32'h0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            if (state_q == IDLE && strobe) begin
                ram_idx_q <= mem_addr[AW+1:2];
                wdata_q   <= mem_write_data;
                write_q   <= mem_write;
                region_q  <= req_region;
            end
            if (issue && op_write && op_region == RGN_LEDR) begin
                ledr_q <= op_wdata[17:0];
            end
            if (state_q == ACK) begin
                rdata_hold_q <= ack_data;
            end
            if ((state_q == IDLE && mem_read && mem_write) ||
                (state_q != IDLE && strobe)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign mem_read_data = (state_q == ACK) ? ack_data : rdata_hold_q;
    assign ledr          = ledr_q;
    assign protocol_err  = proto_err_q;

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int unsigned WORDS = 64;
    localparam logic [31:0] UNMAP = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_write_data = 32'h0;
    logic [17:0] sw = 18'h0;

    // DUT "1": one wait state, DUT "0": no wait states; both share the bus inputs.
    logic        ack1, berr1, perr1, ack0, berr0, perr0;
    logic [31:0] rd1, rd0;
    logic [17:0] ledr1, ledr0;

    mem_responder #(.RAM_WORDS(WORDS), .WAIT_CYCLES(1), .UNMAPPED_DATA(UNMAP)) u_w1 (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_ack(ack1),
        .mem_read_data(rd1), .sw(sw), .ledr(ledr1), .bus_err(berr1), .protocol_err(perr1));

    mem_responder #(.RAM_WORDS(WORDS), .WAIT_CYCLES(0), .UNMAPPED_DATA(UNMAP)) u_w0 (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_ack(ack0),
        .mem_read_data(rd0), .sw(sw), .ledr(ledr0), .bus_err(berr0), .protocol_err(perr0));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        berr;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    // Reference model state
    logic [31:0] ram_m [WORDS];
    logic [17:0] ledr_m = 18'h0;
    logic [17:0] sw_m = 18'h0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitors: pop one expectation per observed ack.
    always @(negedge clk) begin
        exp_t e;
        if (ack1) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                $display("w1 ack cyc=%0d rdata=%h berr=%0b", cyc, rd1, berr1);
                chk("w1_rdata", rd1, e.data);
                chk("w1_bus_err", {31'b0, berr1}, {31'b0, e.berr});
                chk("w1_ack_cycle", cyc, e.cyc);
            end
        end else if (berr1) begin
            chk("w1_bus_err_without_ack", 32'd1, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ack0) begin
            if (q0.size() == 0) begin
                chk("w0_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                $display("w0 ack cyc=%0d rdata=%h berr=%0b", cyc, rd0, berr0);
                chk("w0_rdata", rd0, e.data);
                chk("w0_bus_err", {31'b0, berr0}, {31'b0, e.berr});
                chk("w0_ack_cycle", cyc, e.cyc);
            end
        end else if (berr0) begin
            chk("w0_bus_err_without_ack", 32'd1, 32'd0);
        end
    end

    // Expected response computed from the address map; updates the model for writes.
    function automatic exp_t model_access(input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic [31:0] word;
        word   = a >> 2;
        e.berr = 1'b0;
        e.data = 32'h0;
        e.cyc  = 0;
        if (word < WORDS) begin
            if (wr) ram_m[word] = d;
            else    e.data = ram_m[word];
        end else if (word == (32'h0010_000C >> 2)) begin
            if (wr) ledr_m = d[17:0];
            else    e.data = {14'b0, ledr_m};
        end else if (word == (32'h0010_0010 >> 2)) begin
            if (!wr) e.data = {14'b0, sw_m};
        end else begin
            e.berr = 1'b1;
            if (!wr) e.data = UNMAP;
        end
        return e;
    endfunction

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("pending_acks", q0.size() + q1.size(), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e = model_access(wr, a, d);
        @(posedge clk); #1;
        $display("txn rd=%0b wr=%0b addr=%h wdata=%h exp=%h berr=%0b", rd, wr, a, d, e.data, e.berr);
        e.cyc = cyc + 2; q1.push_back(e);
        e.cyc = cyc + 1; q0.push_back(e);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_write_data = d;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        drain();
        chk("w1_ledr", {14'b0, ledr1}, {14'b0, ledr_m});
        chk("w0_ledr", {14'b0, ledr0}, {14'b0, ledr_m});
    endtask

    task automatic set_sw(input logic [17:0] v);
        @(posedge clk); #1;
        sw = v; sw_m = v;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, {30'b0, ack1, ack0}, 32'd0);
        chk({tag, "_rdata1"}, rd1, 32'd0);
        chk({tag, "_rdata0"}, rd0, 32'd0);
        chk({tag, "_ledr"}, {ledr1[15:0], ledr0[15:0]}, 32'd0);
        chk({tag, "_errs"}, {28'b0, berr1, berr0, perr1, perr0}, 32'd0);
    endtask

    logic [31:0] unm [6] = '{32'h0000_0100, 32'h0020_0000, 32'h0010_0008,
                              32'h0010_0014, 32'hFFFF_FFFC, 32'h8000_0000};

    initial begin
        #3 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        check_reset_outputs("post_reset");

        // Directed cases
        txn(0, 1, 32'h0010_000C, 32'h0000_1337);
        txn(1, 0, 32'h0010_000C, 32'h0);
        txn(0, 1, 32'h0000_0010, 32'hA5A5_5A5A);
        txn(0, 1, 32'h0000_0014, 32'h0000_0000);
        txn(1, 0, 32'h0000_0010, 32'h0);
        txn(1, 0, 32'h0000_0013, 32'h0);           // byte offset ignored
        txn(1, 0, 32'h0020_0000, 32'h0);           // unmapped
        set_sw(18'h2AAAA);
        txn(0, 1, 32'h0010_0010, 32'h0003_FFFF);   // SW is read-only
        txn(1, 0, 32'h0010_0010, 32'h0);
        txn(0, 1, 32'h0000_00FC, 32'h1234_5678);   // last RAM word
        txn(0, 1, 32'h0000_0100, 32'hFFFF_FFFF);   // first word past RAM
        txn(1, 0, 32'h0000_00FC, 32'h0);
        txn(1, 0, 32'h0000_0000, 32'h0);           // must not alias 0x100

        // Fill RAM so every later read has a known value
        for (int i = 0; i < WORDS; i++) txn(0, 1, 32'(i * 4), $urandom);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int          kind;
            bit          wr;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            wr   = $urandom_range(0, 1) == 1;
            if (kind < 5)       a = {24'b0, 6'($urandom_range(0, WORDS - 1)), 2'($urandom)};
            else if (kind == 5) a = 32'h0010_000C;
            else if (kind == 6) a = 32'h0010_0010;
            else if (kind == 7) a = unm[$urandom_range(0, 5)];
            else begin
                set_sw(18'($urandom));
                a = 32'h0010_0010;
                wr = 1'b0;
            end
            txn(!wr, wr, a, $urandom);
        end
        chk("w1_protocol_err_clean", {31'b0, perr1}, 32'd0);
        chk("w0_protocol_err_clean", {31'b0, perr0}, 32'd0);

        // Read and write together: handled as a write, flagged
        txn(1, 1, 32'h0010_000C, 32'h0002_1111);
        chk("w1_protocol_err_both", {31'b0, perr1}, 32'd1);
        chk("w0_protocol_err_both", {31'b0, perr0}, 32'd1);

        // Strobe while busy: ignored, exactly one ack
        begin
            exp_t e;
            e = model_access(1'b0, 32'h0010_0010, 32'h0);
            @(posedge clk); #1;
            $display("txn busy-strobe first read SW exp=%h", e.data);
            e.cyc = cyc + 2; q1.push_back(e);
            e.cyc = cyc + 1; q0.push_back(e);
            mem_read = 1'b1; mem_addr = 32'h0010_0010;
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b1; mem_addr = 32'h0010_000C; mem_write_data = 32'h3;
            @(posedge clk); #1;
            mem_write = 1'b0;
            drain();
            repeat (4) @(posedge clk);
            chk("busy_ledr_unchanged", {14'b0, ledr1}, {14'b0, ledr_m});
        end

        // Reset in the middle of a LEDR write
        @(posedge clk); #1;
        $display("txn reset-during-wait LEDR write");
        mem_write = 1'b1; mem_addr = 32'h0010_000C; mem_write_data = 32'h0001_5555;
        @(posedge clk); #1;
        mem_write = 1'b0;
        reset_n = 1'b0;
        ledr_m = 18'h0;
        #2 check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        check_reset_outputs("after_mid_reset");
        txn(1, 0, 32'h0010_000C, 32'h0);
        txn(1, 0, 32'h0000_0014, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
